// File: rtl/count_bcd_display_pkg.sv
// Shared constants for the BCD display path: segment patterns, FSM encoding,
// and the single shift-add-3 step used by the binary-to-BCD engine.
package count_bcd_display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns; element [d] is the pattern for digit d.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // One double-dabble iteration on {hundreds, tens, units, value[6:0]}.
   function automatic logic [18:0] add3_shift(input logic [18:0] s);
      logic [18:0] r;
      r = s;
      for (int i = 0; i < 3; i++) begin
         if (r[7 + 4*i +: 4] >= 4'd5) r[7 + 4*i +: 4] = r[7 + 4*i +: 4] + 4'd3;
      end
      return {r[17:0], 1'b0};
   endfunction

endpackage

// File: rtl/count_bcd_display_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern; non-BCD nibbles go dark.
module bcd_to_seg7
   import count_bcd_display_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   // NOTE: the default assignment first means every path drives seg_o, so no latch is inferred.
   always_comb begin
      seg_o = SEG_BLANK;
      for (int i = 0; i < 10; i++) begin
         if (digit_i == 4'(i)) seg_o = SEG_TABLE[i];
      end
   end

endmodule

// File: rtl/count_bcd_display.sv
// Converts the 7-bit counter value to three BCD digits and scans them onto one
// active-low 7-segment display with leading-zero blanking.
module count_bcd_display
   import count_bcd_display_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int BLANK_LZ = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  value_in,
   input  logic        value_valid,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd_out,
   output logic [6:0]  seg,
   output logic [2:0]  an
);

   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   state_e      state_q, state_d;
   logic [18:0] shift_q, shift_d;
   logic [2:0]  iter_q, iter_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [11:0] bcd_q, bcd_d;
   logic        pend_valid_q, pend_valid_d;
   logic [6:0]  pend_val_q, pend_val_d;

   logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]       scan_idx_q, scan_idx_d;
   logic [6:0]       seg_q, seg_d;
   logic [2:0]       an_q, an_d;
   logic [3:0]       digit;
   logic             blank;
   logic [6:0]       digit_seg;

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      iter_d       = iter_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      bcd_d        = bcd_q;
      pend_valid_d = pend_valid_q;
      pend_val_d   = pend_val_q;

      case (state_q)
         ST_IDLE: begin
            if (value_valid) begin
               shift_d = {12'b0, value_in};
               iter_d  = 3'd7;
               busy_d  = 1'b1;
               state_d = ST_CONV;
            end
         end
         ST_CONV: begin
            shift_d = add3_shift(shift_q);
            iter_d  = iter_q - 3'd1;
            if (iter_q == 3'd1) state_d = ST_DONE;
            if (value_valid) begin
               pend_valid_d = 1'b1;
               pend_val_d   = value_in;
            end
         end
         ST_DONE: begin
            bcd_d  = shift_q[18:7];
            done_d = 1'b1;
            // A strobe landing on this edge is newer than anything already pending.
            if (value_valid || pend_valid_q) begin
               shift_d      = {12'b0, value_valid ? value_in : pend_val_q};
               iter_d       = 3'd7;
               pend_valid_d = 1'b0;
               state_d      = ST_CONV;
            end else begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         scan_idx_d = (scan_idx_q == 2'd2) ? 2'd0 : scan_idx_q + 2'd1;
      end

      case (scan_idx_q)
         2'd1:    digit = bcd_q[7:4];
         2'd2:    digit = bcd_q[11:8];
         default: digit = bcd_q[3:0];
      endcase

      blank = 1'b0;
      if (BLANK_LZ != 0) begin
         if (scan_idx_q == 2'd2) blank = (bcd_q[11:8] == 4'd0);
         if (scan_idx_q == 2'd1) blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end

      seg_d = blank ? SEG_BLANK : digit_seg;
      an_d  = ~(3'b001 << scan_idx_q);
   end

   bcd_to_seg7 u_seg7 (
      .digit_i (digit),
      .seg_o   (digit_seg)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         iter_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         bcd_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_val_q   <= '0;
         scan_cnt_q   <= '0;
         scan_idx_q   <= '0;
         seg_q        <= SEG_BLANK;
         an_q         <= 3'b111;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         iter_q       <= iter_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         bcd_q        <= bcd_d;
         pend_valid_q <= pend_valid_d;
         pend_val_q   <= pend_val_d;
         scan_cnt_q   <= scan_cnt_d;
         scan_idx_q   <= scan_idx_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bcd_out = bcd_q;
   assign seg     = seg_q;
   assign an      = an_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed bench for count_bcd_display with a fast scanner (SCAN_DIV=4) and blanking on.
module tb_count_bcd_display;

   logic        clk;
   logic        reset;
   logic [6:0]  value_in;
   logic        value_valid;
   logic        busy;
   logic        done;
   logic [11:0] bcd_out;
   logic [6:0]  seg;
   logic [2:0]  an;

   int n_tests = 0;
   int n_fail  = 0;
   int n;
   logic busy_gap;
   logic seen_done, seen_busy;

   count_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .value_in    (value_in),
      .value_valid (value_valid),
      .busy        (busy),
      .done        (done),
      .bcd_out     (bcd_out),
      .seg         (seg),
      .an          (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one strobe; returns at the falling edge just after the sampling edge E0.
   task automatic strobe(input logic [6:0] v);
      @(negedge clk);
      value_in    = v;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
   endtask

   // Counts edges until done is seen; flags any cycle where busy dropped before it.
   task automatic wait_done(input int max_cyc, output int cyc);
      cyc      = 0;
      busy_gap = 1'b0;
      do begin
         @(negedge clk);
         cyc++;
         if (!done && !busy) busy_gap = 1'b1;
      end while (!done && cyc < max_cyc);
      check("done_seen", done, 1'b1);
      check("busy_held", busy_gap, 1'b0);
   endtask

   task automatic check_slot(input string tag, input logic [2:0] an_exp, input logic [6:0] seg_exp);
      int k;
      k = 0;
      @(negedge clk);
      while (an !== an_exp && k < 16) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_an"}, an, an_exp);
      check(tag, seg, seg_exp);
   endtask

   initial begin
      reset       = 1'b1;
      value_valid = 1'b0;
      value_in    = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_seg", seg, 7'h7F);
      check("rst_an", an, 3'b111);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_bcd", bcd_out, 12'h000);
      reset = 1'b0;

      // 127: full-scale conversion, 8-edge latency, one-cycle done
      strobe(7'd127);
      check("c127_busy_e0", busy, 1'b1);
      wait_done(20, n);
      check("c127_latency", n, 8);
      check("c127_bcd", bcd_out, 12'h127);
      check("c127_busy_off", busy, 1'b0);
      check_slot("c127_units", 3'b110, 7'h78);
      check("c127_done_pulse", done, 1'b0);
      check_slot("c127_tens", 3'b101, 7'h24);
      check_slot("c127_hund", 3'b011, 7'h79);

      // 5: both leading zeros blanked
      strobe(7'd5);
      wait_done(20, n);
      check("c5_bcd", bcd_out, 12'h005);
      check_slot("c5_units", 3'b110, 7'h12);
      check_slot("c5_tens", 3'b101, 7'h7F);
      check_slot("c5_hund", 3'b011, 7'h7F);

      // 42 then 99 at E2 and 100 at E5: 99 overwritten, back-to-back conversions
      strobe(7'd42);
      @(negedge clk);
      value_in = 7'd99; value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      repeat (2) @(negedge clk);
      value_in = 7'd100; value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      wait_done(20, n);
      check("c42_latency", n, 3);
      check("c42_bcd", bcd_out, 12'h042);
      check("c42_busy_stays", busy, 1'b1);
      wait_done(20, n);
      check("c100_latency", n, 8);
      check("c100_bcd", bcd_out, 12'h100);
      @(negedge clk);
      check("c100_done_pulse", done, 1'b0);
      check("c100_busy_off", busy, 1'b0);
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("c99_dropped", seen_done, 1'b0);
      check_slot("c100_hund", 3'b011, 7'h79);
      check_slot("c100_tens", 3'b101, 7'h40);
      check_slot("c100_units", 3'b110, 7'h40);

      // Reset at E4 with a pending value
      strobe(7'd42);
      @(negedge clk);
      value_in = 7'd55; value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_bcd", bcd_out, 12'h000);
      check("mid_rst_an", an, 3'b111);
      check("mid_rst_seg", seg, 7'h7F);
      reset = 1'b0;

      // Scanner cadence from a clean reset, display of 000 with blanking
      seen_done = 1'b0;
      seen_busy = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         int idx;
         logic [2:0] an_exp;
         logic [6:0] seg_exp;
         @(negedge clk);
         if (done) seen_done = 1'b1;
         if (busy) seen_busy = 1'b1;
         idx     = ((k - 1) / 4) % 3;
         an_exp  = ~(3'b001 << idx);
         seg_exp = (idx == 0) ? 7'h40 : 7'h7F;
         check($sformatf("scan_an_%0d", k), an, an_exp);
         check($sformatf("scan_seg_%0d", k), seg, seg_exp);
      end
      check("post_rst_no_done", seen_done, 1'b0);
      check("post_rst_no_busy", seen_busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
